// File: rtl/inst_queue_if.sv
// ============================================================================
// Module   : inst_queue_if
// Brief    : Fetch-side and decode-side handshake bundle for inst_queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface inst_queue_if #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
);
    logic                     flush;
    logic                     if_valid;
    logic [31:0]              if_inst;
    logic [XLEN-1:0]          if_pc;
    logic                     if_ready;
    logic                     dec_ready;
    logic                     out_valid;
    logic [31:0]              out_inst;
    logic [XLEN-1:0]          out_pc;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output flush, if_valid, if_inst, if_pc, dec_ready,
        input  if_ready, out_valid, out_inst, out_pc, count
    );

    modport slave (
        input  flush, if_valid, if_inst, if_pc, dec_ready,
        output if_ready, out_valid, out_inst, out_pc, count
    );
endinterface

`default_nettype wire

// File: rtl/inst_queue.sv
// ============================================================================
// Module   : inst_queue
// Brief    : Circular instruction buffer between fetch and decode, flushable.
//            Optional zero-latency empty-queue bypass: INST_QUEUE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_queue #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  wire          clock,
    input  wire          reset,
    inst_queue_if.slave  q
);
    localparam int                 AW      = $clog2(DEPTH);
    localparam logic [31:0]        C_NOP   = 32'h0000_0013;

    logic [31:0]     r_inst_mem [DEPTH];
    logic [XLEN-1:0] r_pc_mem   [DEPTH];
    logic [AW:0]     r_head;
    logic [AW:0]     r_tail;

    logic w_empty;
    logic w_full;
    logic w_bypass;
    logic w_enq;
    logic w_deq;

    assign w_empty = (r_head == r_tail);
    assign w_full  = (r_head[AW-1:0] == r_tail[AW-1:0]) && (r_head[AW] != r_tail[AW]);

`ifdef INST_QUEUE_BYPASS_EN
    assign w_bypass = w_empty && q.if_valid && !q.flush;
`else
    assign w_bypass = 1'b0;
`endif

    assign q.if_ready  = !w_full;
    assign q.out_valid = !q.flush && (!w_empty || w_bypass);
    assign q.count     = r_tail - r_head;

    always_comb begin
        q.out_inst = C_NOP;
        q.out_pc   = '0;
        if (!w_empty) begin
            q.out_inst = r_inst_mem[r_head[AW-1:0]];
            q.out_pc   = r_pc_mem[r_head[AW-1:0]];
        end else if (w_bypass) begin
            q.out_inst = q.if_inst;
            q.out_pc   = q.if_pc;
        end
    end

    // A bypassed instruction taken by the decoder never touches storage.
    assign w_enq = q.if_valid && !w_full && !q.flush && !(w_bypass && q.dec_ready);
    assign w_deq = !w_empty && q.out_valid && q.dec_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_head <= '0;
            r_tail <= '0;
        end else if (q.flush) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_enq) r_tail <= r_tail + 1'b1;
            if (w_deq) r_head <= r_head + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_enq) begin
            r_inst_mem[r_tail[AW-1:0]] <= q.if_inst;
            r_pc_mem[r_tail[AW-1:0]]   <= q.if_pc;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_inst_queue.sv
// ============================================================================
// Module   : tb_inst_queue
// Brief    : Scoreboard bench for inst_queue; honours INST_QUEUE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_queue;
    localparam int          DEPTH = 8;
    localparam int          XLEN  = 32;
    localparam logic [31:0] C_NOP = 32'h0000_0013;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [63:0] sb[$];
    logic [31:0] last_pc;
    logic        popped;

    inst_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN)) qif();

    inst_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clock (clock),
        .reset (reset),
        .q     (qif.slave)
    );

    always #5 clock = ~clock;

    // One cycle: drive at negedge, check against the model, update the model.
    task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                        input logic rdy, input logic fl);
        logic        byp;
        logic        exp_valid;
        logic [63:0] exp_e;
        @(negedge clock);
        qif.if_valid  = v;
        qif.if_inst   = inst;
        qif.if_pc     = pc;
        qif.dec_ready = rdy;
        qif.flush     = fl;
        #1;
        byp = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
        byp = (sb.size() == 0) && v && !fl;
`endif
        exp_valid = !fl && (sb.size() != 0 || byp);
        popped = 1'b0;
        checks++;
        if (qif.out_valid !== exp_valid) begin
            errors++;
            $display("FAIL out_valid: got %b want %b", qif.out_valid, exp_valid);
        end
        checks++;
        if (qif.count !== 4'(sb.size())) begin
            errors++;
            $display("FAIL count: got %0d want %0d", qif.count, sb.size());
        end
        checks++;
        if (qif.if_ready !== (sb.size() < DEPTH)) begin
            errors++;
            $display("FAIL if_ready: got %b want %b", qif.if_ready, sb.size() < DEPTH);
        end
        if (exp_valid) begin
            exp_e = (sb.size() != 0) ? sb[0] : {inst, pc};
            checks++;
            if ({qif.out_inst, qif.out_pc} !== exp_e) begin
                errors++;
                $display("FAIL head: got inst=%h pc=%h want inst=%h pc=%h",
                         qif.out_inst, qif.out_pc, exp_e[63:32], exp_e[31:0]);
            end
        end else if (sb.size() == 0) begin
            checks++;
            if (qif.out_inst !== C_NOP || qif.out_pc !== 32'h0) begin
                errors++;
                $display("FAIL empty_out: got inst=%h pc=%h want inst=%h pc=0",
                         qif.out_inst, qif.out_pc, C_NOP);
            end
        end
        if (fl) begin
            sb.delete();
        end else begin
            if (v && sb.size() < DEPTH) sb.push_back({inst, pc});
            if (exp_valid && rdy) begin
                exp_e   = sb.pop_front();
                last_pc = exp_e[31:0];
                popped  = 1'b1;
            end
        end
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 32'h0, 32'h0, rdy, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
    endtask

    task automatic test_reset();
        qif.if_valid = 1'b0; qif.if_inst = '0; qif.if_pc = '0;
        qif.dec_ready = 1'b0; qif.flush = 1'b0;
        #1;
        checks++;
        if (qif.out_valid !== 1'b0 || qif.if_ready !== 1'b1 || qif.count !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: got v=%b r=%b c=%0d want v=0 r=1 c=0",
                     qif.out_valid, qif.if_ready, qif.count);
        end
        checks++;
        if (qif.out_inst !== C_NOP || qif.out_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_out: got inst=%h pc=%h want %h/0", qif.out_inst, qif.out_pc, C_NOP);
        end
        @(negedge clock);
        reset = 1'b1;
        idle(1'b0);
    endtask

    task automatic test_single();
        step(1'b1, 32'h0050_0093, 32'h0, 1'b0, 1'b0);
        idle(1'b0);
        checks++;
        if (qif.out_valid !== 1'b1 || qif.out_inst !== 32'h0050_0093 || qif.count !== 4'd1) begin
            errors++;
            $display("FAIL single: got v=%b inst=%h c=%0d want v=1 inst=00500093 c=1",
                     qif.out_valid, qif.out_inst, qif.count);
        end
        drain();
    endtask

    task automatic test_fill_drain();
        logic [31:0] exp_pc;
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 32'h1000_0000 + 32'(i), 32'(i * 4), 1'b0, 1'b0);
        step(1'b1, 32'hDEAD_0000, 32'h20, 1'b0, 1'b0);
        checks++;
        if (qif.if_ready !== 1'b0 || qif.count !== 4'd8) begin
            errors++;
            $display("FAIL full: got r=%b c=%0d want r=0 c=8", qif.if_ready, qif.count);
        end
        // Full queue refuses even while a dequeue fires.
        step(1'b1, 32'hDEAD_0001, 32'h24, 1'b1, 1'b0);
        exp_pc = 32'h4;
        for (int i = 0; i < DEPTH - 1; i++) begin
            idle(1'b1);
            checks++;
            if (!popped || last_pc !== exp_pc) begin
                errors++;
                $display("FAIL drain_order: got pc=%h want %h", last_pc, exp_pc);
            end
            exp_pc += 32'h4;
        end
        idle(1'b0);
        checks++;
        if (qif.count !== 4'd0) begin
            errors++;
            $display("FAIL drained: got c=%0d want 0", qif.count);
        end
    endtask

    task automatic test_steady();
        logic [31:0] pc;
        logic [31:0] prev;
        pc = 32'h200;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h2000_0000 + pc, pc, 1'b0, 1'b0);
            pc += 32'h4;
        end
        prev = 32'h1FC;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 32'h2000_0000 + pc, pc, 1'b1, 1'b0);
            pc += 32'h4;
            checks++;
            if (!popped || last_pc !== prev + 32'h4 || qif.count !== 4'd3) begin
                errors++;
                $display("FAIL steady: got pc=%h c=%0d want pc=%h c=3", last_pc, qif.count, prev + 32'h4);
            end
            prev = last_pc;
        end
        drain();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++)
            step(1'b1, 32'h3000_0000 + 32'(i), 32'h80 + 32'(i * 4), 1'b0, 1'b0);
        step(1'b1, 32'h3000_00FF, 32'h100, 1'b1, 1'b1);
        checks++;
        if (qif.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_cycle_valid: got %b want 0", qif.out_valid);
        end
        idle(1'b1);
        checks++;
        if (qif.count !== 4'd0 || qif.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL after_flush: got c=%0d v=%b want c=0 v=0", qif.count, qif.out_valid);
        end
        drain();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'h4000_0000 + 32'(i), 32'h300 + 32'(i * 4), 1'b0, 1'b0);
        @(negedge clock);
        qif.if_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (qif.out_valid !== 1'b0 || qif.if_ready !== 1'b1 || qif.count !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: got v=%b r=%b c=%0d want v=0 r=1 c=0",
                     qif.out_valid, qif.if_ready, qif.count);
        end
        sb.delete();
        @(negedge clock);
        reset = 1'b1;
        idle(1'b1);
    endtask

    task automatic test_bypass();
        step(1'b1, 32'h40B5_0533, 32'h44, 1'b1, 1'b0);
        checks++;
`ifdef INST_QUEUE_BYPASS_EN
        if (qif.out_valid !== 1'b1 || qif.out_pc !== 32'h44) begin
            errors++;
            $display("FAIL bypass_same: got v=%b pc=%h want v=1 pc=44", qif.out_valid, qif.out_pc);
        end
`else
        if (qif.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL nobypass_same: got v=%b want 0", qif.out_valid);
        end
`endif
        idle(1'b0);
        checks++;
`ifdef INST_QUEUE_BYPASS_EN
        if (qif.count !== 4'd0) begin
            errors++;
            $display("FAIL bypass_next: got c=%0d want 0", qif.count);
        end
`else
        if (qif.count !== 4'd1) begin
            errors++;
            $display("FAIL nobypass_next: got c=%0d want 1", qif.count);
        end
`endif
        drain();
    endtask

    task automatic test_back_to_back();
        logic [31:0] pc;
        pc = 32'h500;
        for (int i = 0; i < 40; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, pc, 1'($urandom_range(0, 1)), 1'b0);
            pc += 32'h4;
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_steady();
        test_flush();
        test_async_reset();
        test_bypass();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
